mosi_command_sequencer_ram: RTL
===============================

# mosi_command_sequencer_ram

Parametrised, banked, dual-port command RAM with a built-in read sequencer. It stores strings of MOSI command words for the RHS2000 SPI engine. The host side writes through an auto-incrementing write pointer and can read back any word. The SPI side no longer drives addresses: it starts a sequence over a programmed address window, requests one word per step, and gets one-shot or looping playback with wrap-around. It sits between the USB/host register interface and the RHS2000 SPI controller, all in one clock domain.

## Interface
Parameters:
- DATA_WIDTH, 16, command word width
- ADDR_WIDTH, 13, total depth 2^ADDR_WIDTH words
- BLOCK_ADDR_WIDTH, 10, words per physical block = 2^BLOCK_ADDR_WIDTH; block count = 2^(ADDR_WIDTH-BLOCK_ADDR_WIDTH); must be ≤ ADDR_WIDTH

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_addr_load  in  1  load wr_addr_in into write pointer
- wr_addr_in  in  ADDR_WIDTH  write pointer load value
- wr_en  in  1  write wr_data at write pointer, then pointer+1
- wr_data  in  DATA_WIDTH  write data
- wr_ptr  out  ADDR_WIDTH  current write pointer
- rdback_addr  in  ADDR_WIDTH  host readback address
- rdback_data  out  DATA_WIDTH  readback data, 2-cycle latency
- seq_start_addr  in  ADDR_WIDTH  first address of window
- seq_end_addr  in  ADDR_WIDTH  last address of window (inclusive)
- seq_loop  in  1  1 = continuous looping, 0 = one-shot
- seq_go  in  1  pulse: (re)start sequence
- seq_step  in  1  pulse: fetch next word
- seq_data  out  DATA_WIDTH  fetched command word
- seq_valid  out  1  one-cycle strobe, seq_data valid
- seq_addr  out  ADDR_WIDTH  address of word on seq_data
- seq_busy  out  1  sequencer in RUN
- seq_done  out  1  one-cycle strobe with last one-shot word

## Operation
- Storage is split into blocks of 2^BLOCK_ADDR_WIDTH words. The upper address bits select the block. Write enable goes only to the selected block. The read-side block select is pipelined alongside the RAM read, so output mux selection matches the address that was read.
- Write pointer:
  - wr_addr_load has priority over wr_en in the same cycle: load takes effect and no write occurs.
  - wr_en writes at wr_ptr, then wr_ptr increments modulo 2^ADDR_WIDTH (2^ADDR_WIDTH−1 → 0).
- Read-during-write to the same address on the same cycle is read-first: old data is returned.
- Sequencer FSM:
  - IDLE:
    - seq_go → RUN, ptr = seq_start_addr.
    - seq_step is ignored.
  - RUN:
    - seq_step issues a read at ptr.
    - If ptr ≠ seq_end_addr: ptr = ptr+1 modulo depth.
    - If ptr = seq_end_addr and seq_loop=1: ptr = seq_start_addr.
    - If ptr = seq_end_addr and seq_loop=0: → IDLE. The read is still issued and completes. seq_done is asserted with that word's seq_valid.
  - seq_go in RUN restarts at seq_start_addr. Reads already in flight still complete.
  - seq_go and seq_step in the same cycle: go wins and the step is dropped.
- seq_start_addr > seq_end_addr: the window wraps through the top of the address space (e.g. 8190, 8191, 0, 1).
- seq_start_addr = seq_end_addr: single-word window.
- Window, seq_loop and seq_end_addr are sampled live while in RUN. Software changes them only in IDLE.

## Timing
- Read latency is 2 cycles for both ports (RAM register + mux register). A step at edge N gives seq_valid/seq_data/seq_addr at edge N+2.
- seq_step may be asserted every cycle. Throughput is 1 word/cycle with no bubbles, including across the loop wrap.
- seq_busy rises the cycle after seq_go and falls the cycle after the final one-shot step is accepted.
- Reset (asynchronous assert, synchronous release): state IDLE; wr_ptr, ptr and all read pipeline stages 0; seq_valid, seq_done, seq_busy, seq_data, seq_addr and rdback_data all 0. RAM contents are not cleared.
- Reset mid-sequence discards any in-flight seq_valid.

## Test plan
- Load wr_ptr=0, write 0x1000..0x1007 to addresses 0..7 → wr_ptr=8; rdback_addr=5 returns 0x1005 two cycles later.
- Block boundary: write 1023→0xAAAA and 1024→0xBBBB; readback each → correct word, proving the block select and mux register are aligned.
- One-shot window 2..4 with seq_step held high → seq_data 0x1002, 0x1003, 0x1004 on consecutive cycles; seq_done with 0x1004; seq_busy low; further steps produce no seq_valid.
- Loop window 8190..1 (wrap), 6 consecutive steps → seq_addr 8190, 8191, 0, 1, 8190, 8191, no gaps, no seq_done.
- Write addr 3 = 0x5555 on the same cycle a step reads addr 3 (previously 0x1003) → seq_data 0x1003; the next pass returns 0x5555.
- Assert reset while RUN with two reads in flight → no seq_valid afterwards; all outputs 0; RAM still holds 0x1000 at addr 0.

Source files
------------

// File: rtl/mosi_command_sequencer_ram_if.sv
// Bus bundle for the MOSI command sequencer RAM.
// The host register side (write pointer, write data, readback) and the
// SPI side (window, go/step, fetched word and strobes) share one clock
// domain, so they are grouped into a single bundle.
//   slave  : the RAM/sequencer (consumes commands, produces data/status)
//   master : the host/SPI controller driving it
interface mosi_command_sequencer_ram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13
);
    // host write / readback side
    logic                  wr_addr_load;
    logic [ADDR_WIDTH-1:0] wr_addr_in;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rdback_addr;
    logic [DATA_WIDTH-1:0] rdback_data;
    // SPI sequencer side
    logic [ADDR_WIDTH-1:0] seq_start_addr;
    logic [ADDR_WIDTH-1:0] seq_end_addr;
    logic                  seq_loop;
    logic                  seq_go;
    logic                  seq_step;
    logic [DATA_WIDTH-1:0] seq_data;
    logic                  seq_valid;
    logic [ADDR_WIDTH-1:0] seq_addr;
    logic                  seq_busy;
    logic                  seq_done;

    modport slave (
        input  wr_addr_load, wr_addr_in, wr_en, wr_data, rdback_addr,
               seq_start_addr, seq_end_addr, seq_loop, seq_go, seq_step,
        output wr_ptr, rdback_data, seq_data, seq_valid, seq_addr,
               seq_busy, seq_done
    );

    modport master (
        output wr_addr_load, wr_addr_in, wr_en, wr_data, rdback_addr,
               seq_start_addr, seq_end_addr, seq_loop, seq_go, seq_step,
        input  wr_ptr, rdback_data, seq_data, seq_valid, seq_addr,
               seq_busy, seq_done
    );
endinterface

// File: rtl/mosi_command_sequencer_ram.sv
// Banked command RAM with an auto-incrementing host write pointer, a host
// readback port and a window read sequencer for the RHS2000 SPI engine.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - slave side of mosi_command_sequencer_ram_if (host write/readback
//           signals plus sequencer window, go/step, data and status strobes)
// Both read paths are two registers deep: the block RAM output register and
// the block-select mux register. The block select travels with the read so
// the mux always picks the block that was actually addressed.
module mosi_command_sequencer_ram #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 13,
    parameter int BLOCK_ADDR_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    mosi_command_sequencer_ram_if.slave   bus
);
    localparam int NUM_BLOCKS  = 1 << (ADDR_WIDTH - BLOCK_ADDR_WIDTH);
    localparam int BLOCK_DEPTH = 1 << BLOCK_ADDR_WIDTH;
    localparam int SEL_WIDTH   = (ADDR_WIDTH > BLOCK_ADDR_WIDTH) ?
                                 (ADDR_WIDTH - BLOCK_ADDR_WIDTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // block index is the upper address bits; zero when only one block exists
    function automatic logic [SEL_WIDTH-1:0] block_of(input logic [ADDR_WIDTH-1:0] addr);
        block_of = SEL_WIDTH'(addr >> BLOCK_ADDR_WIDTH);
    endfunction

    function automatic logic [BLOCK_ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] addr);
        word_of = BLOCK_ADDR_WIDTH'(addr);
    endfunction

    state_t                        state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]         ptr_r, ptr_nxt_s;
    logic                          seq_rd_s, seq_last_s;
    logic                          busy_r;

    logic [ADDR_WIDTH-1:0]         wr_ptr_r;
    logic                          wr_fire_s;
    logic [SEL_WIDTH-1:0]          wr_blk_s;
    logic [BLOCK_ADDR_WIDTH-1:0]   wr_word_s, rb_word_s, seq_word_s;

    logic [DATA_WIDTH-1:0]         rb_q_s  [NUM_BLOCKS];
    logic [DATA_WIDTH-1:0]         seq_q_s [NUM_BLOCKS];

    logic [SEL_WIDTH-1:0]          rb_sel1_r, seq_sel1_r;
    logic                          seq_v1_r, seq_last1_r;
    logic [ADDR_WIDTH-1:0]         seq_addr1_r;

    logic [DATA_WIDTH-1:0]         rdback_data_r, seq_data_r;
    logic [ADDR_WIDTH-1:0]         seq_addr_r;
    logic                          seq_valid_r, seq_done_r;

    // load has priority: a load cycle never writes
    assign wr_fire_s  = bus.wr_en & ~bus.wr_addr_load;
    assign wr_blk_s   = block_of(wr_ptr_r);
    assign wr_word_s  = word_of(wr_ptr_r);
    assign rb_word_s  = word_of(bus.rdback_addr);
    assign seq_word_s = word_of(ptr_r);

    // host write pointer: load, or post-increment after each write (wraps)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
        end else if (bus.wr_addr_load) begin
            wr_ptr_r <= bus.wr_addr_in;
        end else if (bus.wr_en) begin
            wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
        end
    end

    // sequencer next-state: go restarts and swallows a simultaneous step
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        seq_rd_s    = 1'b0;
        seq_last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.seq_go) begin
                    state_nxt_s = ST_RUN;
                    ptr_nxt_s   = bus.seq_start_addr;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.seq_go) begin
                    ptr_nxt_s = bus.seq_start_addr;
                end else if (bus.seq_step) begin
                    seq_rd_s = 1'b1;
                    if (ptr_r != bus.seq_end_addr) begin
                        ptr_nxt_s = ptr_r + ADDR_WIDTH'(1);
                    end else if (bus.seq_loop) begin
                        ptr_nxt_s = bus.seq_start_addr;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        seq_last_s  = 1'b1;
                    end
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // sequencer state, pointer and busy flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= {ADDR_WIDTH{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
        end
    end

    for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_block
        logic [DATA_WIDTH-1:0] mem_r [BLOCK_DEPTH];
        logic [DATA_WIDTH-1:0] rb_q_r, seq_q_r;

        // block write port, enabled only for the addressed block
        always_ff @(posedge clk) begin
            if (wr_fire_s && (wr_blk_s == SEL_WIDTH'(b))) begin
                mem_r[wr_word_s] <= bus.wr_data;
            end
        end

        // block read registers; non-blocking reads give read-first behaviour
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rb_q_r  <= {DATA_WIDTH{1'b0}};
                seq_q_r <= {DATA_WIDTH{1'b0}};
            end else begin
                rb_q_r  <= mem_r[rb_word_s];
                seq_q_r <= mem_r[seq_word_s];
            end
        end

        assign rb_q_s[b]  = rb_q_r;
        assign seq_q_s[b] = seq_q_r;
    end

    // stage 1: block select and sequencer tags travel with the RAM read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rb_sel1_r   <= {SEL_WIDTH{1'b0}};
            seq_sel1_r  <= {SEL_WIDTH{1'b0}};
            seq_v1_r    <= 1'b0;
            seq_last1_r <= 1'b0;
            seq_addr1_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            rb_sel1_r   <= block_of(bus.rdback_addr);
            seq_sel1_r  <= block_of(ptr_r);
            seq_v1_r    <= seq_rd_s;
            seq_last1_r <= seq_last_s;
            seq_addr1_r <= ptr_r;
        end
    end

    // stage 2: output mux registers; sequencer word/address hold between strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdback_data_r <= {DATA_WIDTH{1'b0}};
            seq_data_r    <= {DATA_WIDTH{1'b0}};
            seq_addr_r    <= {ADDR_WIDTH{1'b0}};
            seq_valid_r   <= 1'b0;
            seq_done_r    <= 1'b0;
        end else begin
            rdback_data_r <= rb_q_s[rb_sel1_r];
            seq_valid_r   <= seq_v1_r;
            seq_done_r    <= seq_v1_r & seq_last1_r;
            if (seq_v1_r) begin
                seq_data_r <= seq_q_s[seq_sel1_r];
                seq_addr_r <= seq_addr1_r;
            end
        end
    end

    assign bus.wr_ptr      = wr_ptr_r;
    assign bus.rdback_data = rdback_data_r;
    assign bus.seq_data    = seq_data_r;
    assign bus.seq_addr    = seq_addr_r;
    assign bus.seq_valid   = seq_valid_r;
    assign bus.seq_done    = seq_done_r;
    assign bus.seq_busy    = busy_r;
endmodule
